serial_parity_checker: RTL and testbench

//   Parametrised successor to the single-bit serial parity generator.

---
 rtl/serial_parity_checker.sv | 109 ++++++++++
 tb/tb_serial_parity_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Framed serial word receiver: start bit, WORD_BITS data bits (LSB first), parity bit, stop bit.
// Reports parity/framing errors per frame, keeps a saturating error count and a running data parity z.
module serial_parity_checker #(
  parameter int WORD_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 odd_mode,
  input  logic                 clear,
  output logic                 z,
  output logic                 busy,
  output logic                 word_done,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     err_count
);

  localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] sr;
  logic                 odd_l;
  logic                 perr_l;
  logic                 frame_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (x_valid) begin
      case (state)
        IDLE:    if (!x) state_nx = DATA;
        DATA:    if (bit_cnt == LAST) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      sr         <= '0;
      z          <= 1'b0;
      odd_l      <= 1'b0;
      perr_l     <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (x_valid) begin
        case (state)
          IDLE: begin
            if (!x) begin
              bit_cnt <= '0;
              z       <= 1'b0;
              odd_l   <= odd_mode;
            end
          end
          DATA: begin
            sr[bit_cnt] <= x;
            z           <= z ^ x;
            // Counter parks on the last index instead of wrapping.
            if (bit_cnt != LAST) bit_cnt <= bit_cnt + CW'(1);
          end
          PARITY: perr_l <= z ^ x ^ odd_l;
          STOP: begin
            data_out   <= sr;
            parity_err <= perr_l;
            frame_err  <= ~x;
            word_done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign frame_bad = x_valid && (state == STOP) && (perr_l || !x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_count <= '0;
    else if (clear)                            err_count <= '0;
    else if (frame_bad && (err_count != '1))   err_count <= err_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: vector table of frames, scoreboard on word_done, plus
// hand sequences for clear, mid-frame reset and counter saturation (CNT_W=2 instance).
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       x, x_valid, odd_mode, clear, clear2;
  logic       z, busy, word_done, parity_err, frame_err;
  logic [7:0] data_out, err_count;
  logic       z2, busy2, wd2, perr2, ferr2;
  logic [7:0] dout2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.WORD_BITS(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .odd_mode(odd_mode), .clear(clear),
    .z(z), .busy(busy), .word_done(word_done), .data_out(data_out),
    .parity_err(parity_err), .frame_err(frame_err), .err_count(err_count)
  );

  serial_parity_checker #(.WORD_BITS(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .x(x), .x_valid(x_valid), .odd_mode(odd_mode), .clear(clear2),
    .z(z2), .busy(busy2), .word_done(wd2), .data_out(dout2),
    .parity_err(perr2), .frame_err(ferr2), .err_count(cnt2)
  );

  typedef struct {
    logic [7:0]  data;
    logic        odd;
    logic        pbit;
    logic        sbit;
    bit          gapped;
    int unsigned idle_after;
    logic        perr;
    logic        ferr;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Scoreboard: every word_done pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n && word_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word_done: got 1, expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", data_out, e.data);
        chk("parity_err", parity_err, e.perr);
        chk("frame_err", frame_err, e.ferr);
        chk("err_count", err_count, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish by 100000");
    $fatal(1);
  end

  task automatic drive(input logic b, input bit gapped);
    int unsigned g;
    g = gapped ? $urandom_range(1, 3) : 0;
    repeat (g) begin
      @(negedge clk);
      x_valid = 1'b0;
      x       = 1'($urandom_range(0, 1));
      clear2  = 1'b0;
    end
    @(negedge clk);
    x       = b;
    x_valid = 1'b1;
    clear2  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic odd, input logic pbit, input logic sbit,
                            input bit gapped, input logic c2,
                            input logic perr, input logic ferr, input logic [7:0] cnt);
    exp_t e;
    odd_mode = odd;
    drive(1'b0, gapped);
    for (int i = 0; i < 8; i++) begin
      drive(d[i], gapped);
      if (i == 1) odd_mode = ~odd;
    end
    @(posedge clk); #1;
    chk("z_after_data", z, ^d);
    chk("busy_in_frame", busy, 1'b1);
    drive(pbit, gapped);
    chk("z_held", z, ^d);
    e.data = d; e.perr = perr; e.ferr = ferr; e.cnt = cnt;
    sb.push_back(e);
    drive(sbit, gapped);
    clear2 = c2;
    @(posedge clk); #1;
    chk("word_done_latency", word_done, 1'b1);
    chk("busy_after_stop", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hB5, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{8'hB5, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd1};
    vecs[2] = '{8'hB5, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'd1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 8'd2};
    vecs[4] = '{8'hB5, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd2};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'd2};

    rst_n = 1'b0; rst2_n = 1'b0;
    x = 1'b1; x_valid = 1'b0; odd_mode = 1'b0; clear = 1'b0; clear2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", z, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_word_done", word_done, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_err_count", err_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int unsigned k = 0; k < 6; k++) begin
      send_frame(vecs[k].data, vecs[k].odd, vecs[k].pbit, vecs[k].sbit, vecs[k].gapped, 1'b0,
                 vecs[k].perr, vecs[k].ferr, vecs[k].cnt);
      idle(vecs[k].idle_after);
    end

    // clear leaves the held error flags alone
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    idle(1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_err_count", err_count, 8'd0);
    chk("clear_keeps_frame_err", frame_err, 1'b1);
    chk("clear_keeps_data_out", data_out, 8'h5A);
    @(negedge clk);
    clear = 1'b0;
    idle(1);

    // reset in the middle of a frame
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    @(posedge clk); #1;
    chk("busy_before_reset", busy, 1'b1);
    chk("z_before_reset", z, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; x_valid = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_z", z, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_word_done", word_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'hB5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle(2);

    // saturation on the 2-bit counter instance
    @(negedge clk);
    rst2_n = 1'b1;
    idle(2);
    for (int unsigned k = 0; k < 5; k++) begin
      send_frame(8'hB5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(k + 1));
      chk("sat_cnt2", cnt2, (k + 1 > 3) ? 2'd3 : 2'(k + 1));
      chk("sat_perr2", perr2, 1'b1);
      idle(1);
    end
    send_frame(8'hB5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6);
    chk("clear_beats_inc", cnt2, 2'd0);
    chk("clear_keeps_perr2", perr2, 1'b1);
    chk("dut2_data_out", dout2, 8'hB5);
    chk("dut2_word_done", wd2, 1'b1);
    chk("dut2_frame_err", ferr2, 1'b0);
    chk("dut2_z", z2, 1'b1);
    chk("dut2_busy", busy2, 1'b0);
    idle(3);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
